// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the word/byte memory controller.
//   state_e      controller sequencing states
//   SIZE_BYTE/SIZE_WORD  encodings of the request size bit
//   READ_LAT_DEF default ram read latency
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RSP
  } state_e;

  localparam logic SIZE_BYTE    = 1'b0;
  localparam logic SIZE_WORD    = 1'b1;
  localparam int   READ_LAT_DEF = 1;

endpackage

// File: rtl/mem_word_ctrl_if.sv
// mem_word_ctrl_if: request/response handshake bundle of the memory controller.
//   req_*  : request from master (valid/ready, we, size, byte address, store data)
//   rsp_*  : response to master (valid/ready, load data)
//   master : requester side, slave : controller side
interface mem_word_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic                req_size;
  logic [ADDR_W-1:0]   req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: splits byte / 16-bit little-endian word loads and stores into
// one or two single-byte accesses on a byte-wide ram, returns completion on a
// response handshake.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          request/response handshake (slave side)
//   ram_address  ram byte address        (registered)
//   ram_datain   ram write data          (registered)
//   ram_wen      ram write strobe        (registered)
//   ram_ren      ram read strobe         (registered)
//   ram_q        ram read data, valid READ_LAT cycles after ram_ren is sampled
module mem_word_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_word_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic                size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_hi_q;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_datain_q, ram_datain_d;
  logic                ram_wen_q, ram_wen_d;
  logic                ram_ren_q, ram_ren_d;
  logic                accept, wait_done;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign wait_done = (wcnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. Load/store direction is carried by the state itself, so only
  // size, address and the high store byte need latching.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = bus.req_we ? WR_LO : RD_LO;
      WR_LO:   state_d = (size_q == SIZE_WORD) ? WR_HI : RSP;
      WR_HI:   state_d = RSP;
      RD_LO:   state_d = WAIT_LO;
      WAIT_LO: if (wait_done) state_d = (size_q == SIZE_WORD) ? RD_HI : RSP;
      RD_HI:   state_d = WAIT_HI;
      WAIT_HI: if (wait_done) state_d = RSP;
      RSP:     if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every ram
  // strobe and the response come straight from flops. LO accesses are only
  // entered from IDLE, hence they take the address/data from the live request.
  always_comb begin
    ram_address_d = ram_address_q;
    ram_datain_d  = ram_datain_q;
    ram_wen_d     = 1'b0;
    ram_ren_d     = 1'b0;
    wcnt_d        = wcnt_q;
    rdata_d       = rdata_q;
    case (state_d)
      WR_LO: begin
        ram_wen_d     = 1'b1;
        ram_address_d = bus.req_addr;
        ram_datain_d  = bus.req_wdata[DATA_W-1:0];
      end
      WR_HI: begin
        ram_wen_d     = 1'b1;
        ram_address_d = addr_q + ADDR_W'(1);
        ram_datain_d  = wdata_hi_q;
      end
      RD_LO: begin
        ram_ren_d     = 1'b1;
        ram_address_d = bus.req_addr;
      end
      RD_HI: begin
        ram_ren_d     = 1'b1;
        ram_address_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
    // Counter is zero on the first wait cycle; last wait cycle sees READ_LAT-1.
    if (state_q == RD_LO || state_q == RD_HI)        wcnt_d = '0;
    else if (state_q == WAIT_LO || state_q == WAIT_HI) wcnt_d = wcnt_q + CNT_W'(1);
    // Clearing on accept yields 0 for stores and a zero high byte for byte loads.
    if (accept) rdata_d = '0;
    if (state_q == WAIT_LO && wait_done) rdata_d[DATA_W-1:0] = ram_q;
    if (state_q == WAIT_HI && wait_done) rdata_d[2*DATA_W-1:DATA_W] = ram_q;
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q        <= SIZE_BYTE;
      addr_q        <= '0;
      wdata_hi_q    <= '0;
      wcnt_q        <= '0;
      rdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      ram_address_q <= '0;
      ram_datain_q  <= '0;
      ram_wen_q     <= 1'b0;
      ram_ren_q     <= 1'b0;
    end else begin
      if (accept) begin
        size_q     <= bus.req_size;
        addr_q     <= bus.req_addr;
        wdata_hi_q <= bus.req_wdata[2*DATA_W-1:DATA_W];
      end
      wcnt_q        <= wcnt_d;
      rdata_q       <= rdata_d;
      rsp_valid_q   <= rsp_valid_d;
      ram_address_q <= ram_address_d;
      ram_datain_q  <= ram_datain_d;
      ram_wen_q     <= ram_wen_d;
      ram_ren_q     <= ram_ren_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign ram_address   = ram_address_q;
  assign ram_datain    = ram_datain_q;
  assign ram_wen       = ram_wen_q;
  assign ram_ren       = ram_ren_q;

endmodule

// File: doc/mem_word_ctrl.md
# mem_word_ctrl

Request-side controller feeding the byte-wide `ram` block. It accepts byte and 16-bit word load/store requests over a valid/ready handshake. Each request is sequenced into one or two single-byte `ram` accesses, and completion (with read data) is returned on a response handshake. Words are little-endian: the low byte is at `A` and the high byte at `A+1`.

## Interface
Parameters:
- `ADDR_W`, 16: `ram` address width.
- `DATA_W`, 8: `ram` data width. A word is `2*DATA_W`.
- `READ_LAT`, 1: cycles from `ram_ren` sampled to `ram_q` valid. Legal range is 1..4.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  1  0 = byte, 1 = word.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_wdata`  in  `2*DATA_W`  store data; byte store uses `[DATA_W-1:0]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  `2*DATA_W`  load data; 0 for stores.
- `ram_address`  out  `ADDR_W`  to `ram` address.
- `ram_datain`  out  `DATA_W`  to `ram` datain.
- `ram_wen`  out  1  to `ram` wen.
- `ram_ren`  out  1  to `ram` ren.
- `ram_q`  in  `DATA_W`  from `ram` q.

## Operation
- **States:** IDLE, WR_LO, WR_HI, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RSP.
- **IDLE:**
  - `req_ready` = 1, and only in IDLE.
  - On `req_valid && req_ready`, latch `we`, `size`, `addr`, `wdata`.
  - Store goes to WR_LO; load goes to RD_LO.
- **WR_LO:** `ram_wen`=1, `ram_address`=A, `ram_datain`=wdata low byte. Next is WR_HI if word, else RSP.
- **WR_HI:** `ram_wen`=1, `ram_address`=A+1 mod 2^ADDR_W, `ram_datain`=wdata high byte. Next is RSP.
- **RD_LO:** `ram_ren`=1, `ram_address`=A. Next is WAIT_LO.
- **WAIT_LO:**
  - Stay `READ_LAT` cycles, counted by a wait counter.
  - On the last cycle, capture `ram_q` into rdata low byte.
  - Next is RD_HI if word, else RSP.
- **RD_HI / WAIT_HI:** Same as RD_LO / WAIT_LO, using address A+1 and capturing the high byte. Next is RSP.
- **RSP:**
  - `rsp_valid`=1; `rsp_rdata` is held stable.
  - Leave to IDLE on `rsp_ready`. Stall indefinitely otherwise.
- **Address wrap:** A = 0xFFFF with a word access gives a high-byte address of 0x0000. No error is flagged.
- **Byte load:** `rsp_rdata` = {8'h00, byte}.
- **Store response:** `rsp_rdata` = 0.
- **Strobes:** `ram_wen` and `ram_ren` are never both 1. Each is high for exactly one cycle per byte access.
- **Idle `ram` outputs:** `ram_address` and `ram_datain` hold their last values. Strobes are 0.
- **Reset (async, any time, including mid-access):**
  - State goes to IDLE; the in-flight request is dropped with no response.
  - `ram_wen`=0, `ram_ren`=0, `ram_address`=0, `ram_datain`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=1.

## Timing
- **Output sources:**
  - All `ram_*` outputs, `rsp_valid` and `rsp_rdata` come straight from flops.
  - `req_ready` is decoded from the state register.
- **Accept:** acceptance at edge 0 means the first `ram` strobe is driven in cycle 1 (after edge 0).
- **Latency, acceptance to first cycle of `rsp_valid`:**
  - Byte store: 2 cycles.
  - Word store: 3 cycles.
  - Byte load: `READ_LAT`+2 cycles.
  - Word load: 2·`READ_LAT`+3 cycles.
- **Back-to-back:** `rsp_valid && rsp_ready` at edge N returns to IDLE. A new request can be accepted at edge N+1. There is no overlap between requests.
- **Response stall:** `rsp_valid` stays high and `rsp_rdata` stays constant until the `rsp_ready` edge.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum;
  - `SIZE_BYTE`=0 and `SIZE_WORD`=1;
  - a default of 1 for `READ_LAT`.
- No sub-module. The wait counter (width `$clog2(READ_LAT+1)`) and byte sequencing stay inline.
- The `ram` instance lives in the parent, not inside this block.

## Test plan
- **Word store then load:** store word 0x12AB to 0x0000, then load word at 0x0000.
  - Required: `ram` writes addr 0 = 0xAB, then addr 1 = 0x12.
  - Required: `rsp_rdata` = 0x12AB, with `rsp_valid` 5 cycles after acceptance (`READ_LAT`=1).
- **Byte store then load:** store byte 0xFF to 0x0001, then load byte at 0x0001.
  - Required: single `ram_wen` pulse; store response at +2.
  - Required: load returns 0x00FF at +3.
- **Wrap-around:** store word 0xBEEF to 0xFFFF, then byte loads from 0xFFFF and 0x0000.
  - Required: 0x00EF and 0x00BE.
- **Response backpressure:** hold `rsp_ready`=0 for 4 cycles on a word load.
  - Required: `rsp_valid` and `rsp_rdata` are stable throughout.
  - Required: `req_ready`=0 throughout; a request offered meanwhile is not accepted.
- **Mid-access reset:** assert `rst_n`=0 during WAIT_LO of a word load.
  - Required: strobes drop immediately and all outputs take reset values.
  - Required: no `rsp_valid`; the next request completes normally.
- **`READ_LAT`=3 build:** word load.
  - Required: `rsp_valid` at +9, with correct data.
